// File: rtl/vdram_slot_sched_if.sv
// Slot scheduler bus: raster/requester side (master) and scheduler side (slave).
// VDRAM_SCHED_STATS_EN adds the per-frame slot statistics outputs.
interface vdram_slot_sched_if #(
  parameter int unsigned BUDGET_W = 8
);
  logic                c3;
  logic                line_start_s;
  logic                frame_start;
  logic                video_go;
  logic                ts_req;
  logic                dma_req;
  logic                cpu_req;
  logic [3:0]          gnt;
  logic                video_pre_next;
  logic                ts_gnt_stb;
  logic                dma_gnt_stb;
  logic                cpu_gnt_stb;
  logic [BUDGET_W-1:0] ts_budget_left;
`ifdef VDRAM_SCHED_STATS_EN
  logic [15:0]         stat_vid;
  logic [15:0]         stat_ts;
  logic [15:0]         stat_dma;
  logic [15:0]         stat_cpu;
  logic [15:0]         stat_idle;

  modport master (
    output c3, line_start_s, frame_start, video_go, ts_req, dma_req, cpu_req,
    input  gnt, video_pre_next, ts_gnt_stb, dma_gnt_stb, cpu_gnt_stb, ts_budget_left,
    input  stat_vid, stat_ts, stat_dma, stat_cpu, stat_idle
  );
  modport slave (
    input  c3, line_start_s, frame_start, video_go, ts_req, dma_req, cpu_req,
    output gnt, video_pre_next, ts_gnt_stb, dma_gnt_stb, cpu_gnt_stb, ts_budget_left,
    output stat_vid, stat_ts, stat_dma, stat_cpu, stat_idle
  );
`else
  modport master (
    output c3, line_start_s, frame_start, video_go, ts_req, dma_req, cpu_req,
    input  gnt, video_pre_next, ts_gnt_stb, dma_gnt_stb, cpu_gnt_stb, ts_budget_left
  );
  modport slave (
    input  c3, line_start_s, frame_start, video_go, ts_req, dma_req, cpu_req,
    output gnt, video_pre_next, ts_gnt_stb, dma_gnt_stb, cpu_gnt_stb, ts_budget_left
  );
`endif
endinterface

// File: rtl/vdram_slot_sched.sv
// Per-slot DRAM scheduler: grants each 4-clock slot to video, TS, DMA or CPU.
// Optional per-frame slot statistics are enabled with VDRAM_SCHED_STATS_EN.
module vdram_slot_sched #(
  parameter int unsigned          BUDGET_W    = 8,
  parameter logic [BUDGET_W-1:0]  TS_BUDGET   = BUDGET_W'(64),
  parameter logic [3:0]           CPU_MAXWAIT = 4'd6
) (
  input  logic               clk,
  input  logic               rst_n,
  vdram_slot_sched_if.slave  bus
);

  // One-hot encoding matches the gnt bit order {cpu,dma,ts,vid}.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0000,
    S_VID  = 4'b0001,
    S_TS   = 4'b0010,
    S_DMA  = 4'b0100,
    S_CPU  = 4'b1000
  } state_t;

  state_t     state;
  state_t     nxt_c;
  logic       rr_ptr;       // 0: DMA has RR priority, 1: CPU
  logic       rr_sel_c;
  logic       rr_grant_c;
  logic [3:0] cpu_wait;

  // Priority selection for the slot decided on this c3 edge.
  always_comb begin
    nxt_c      = S_IDLE;
    rr_grant_c = 1'b0;
    rr_sel_c   = bus.frame_start ? 1'b0 : rr_ptr;
    if (bus.video_go) begin
      nxt_c = S_VID;
    end else if (bus.cpu_req && (cpu_wait >= CPU_MAXWAIT)) begin
      nxt_c = S_CPU;
    end else if (bus.ts_req && (bus.ts_budget_left != '0)) begin
      nxt_c = S_TS;
    end else if (bus.dma_req && bus.cpu_req) begin
      rr_grant_c = 1'b1;
      nxt_c      = rr_sel_c ? S_CPU : S_DMA;
    end else if (bus.dma_req) begin
      rr_grant_c = 1'b1;
      nxt_c      = S_DMA;
    end else if (bus.cpu_req) begin
      rr_grant_c = 1'b1;
      nxt_c      = S_CPU;
    end
  end

  assign bus.gnt = state;

  // Slot owner, strobes, TS budget, RR pointer and CPU starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      bus.video_pre_next <= 1'b0;
      bus.ts_gnt_stb     <= 1'b0;
      bus.dma_gnt_stb    <= 1'b0;
      bus.cpu_gnt_stb    <= 1'b0;
      bus.ts_budget_left <= TS_BUDGET;
      rr_ptr             <= 1'b0;
      cpu_wait           <= 4'd0;
    end else begin
      bus.video_pre_next <= 1'b0;
      bus.ts_gnt_stb     <= 1'b0;
      bus.dma_gnt_stb    <= 1'b0;
      bus.cpu_gnt_stb    <= 1'b0;
      if (bus.c3) begin
        state              <= nxt_c;
        bus.video_pre_next <= (nxt_c == S_VID);
        bus.ts_gnt_stb     <= (nxt_c == S_TS);
        bus.dma_gnt_stb    <= (nxt_c == S_DMA);
        bus.cpu_gnt_stb    <= (nxt_c == S_CPU);

        if (rr_grant_c) begin
          rr_ptr <= (nxt_c == S_DMA);
        end else begin
          rr_ptr <= rr_sel_c;
        end

        if (!bus.cpu_req || (nxt_c == S_CPU)) begin
          cpu_wait <= 4'd0;
        end else if (cpu_wait != 4'hF) begin
          cpu_wait <= cpu_wait + 4'd1;
        end

        // Line reload beats a coincident TS decrement.
        if (bus.line_start_s) begin
          bus.ts_budget_left <= TS_BUDGET;
        end else if ((nxt_c == S_TS) && (bus.ts_budget_left != '0)) begin
          bus.ts_budget_left <= bus.ts_budget_left - BUDGET_W'(1);
        end
      end
    end
  end

`ifdef VDRAM_SCHED_STATS_EN
  logic [15:0] cnt_vid;
  logic [15:0] cnt_ts;
  logic [15:0] cnt_dma;
  logic [15:0] cnt_cpu;
  logic [15:0] cnt_idle;

  function automatic logic [15:0] bump(input logic [15:0] v, input logic hit);
    return (hit && (v != 16'hFFFF)) ? (v + 16'd1) : v;
  endfunction

  // Frame counters; the frame_start decision itself opens the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_vid       <= 16'd0;
      cnt_ts        <= 16'd0;
      cnt_dma       <= 16'd0;
      cnt_cpu       <= 16'd0;
      cnt_idle      <= 16'd0;
      bus.stat_vid  <= 16'd0;
      bus.stat_ts   <= 16'd0;
      bus.stat_dma  <= 16'd0;
      bus.stat_cpu  <= 16'd0;
      bus.stat_idle <= 16'd0;
    end else if (bus.c3) begin
      if (bus.frame_start) begin
        bus.stat_vid  <= cnt_vid;
        bus.stat_ts   <= cnt_ts;
        bus.stat_dma  <= cnt_dma;
        bus.stat_cpu  <= cnt_cpu;
        bus.stat_idle <= cnt_idle;
        cnt_vid       <= 16'(nxt_c == S_VID);
        cnt_ts        <= 16'(nxt_c == S_TS);
        cnt_dma       <= 16'(nxt_c == S_DMA);
        cnt_cpu       <= 16'(nxt_c == S_CPU);
        cnt_idle      <= 16'(nxt_c == S_IDLE);
      end else begin
        cnt_vid  <= bump(cnt_vid,  nxt_c == S_VID);
        cnt_ts   <= bump(cnt_ts,   nxt_c == S_TS);
        cnt_dma  <= bump(cnt_dma,  nxt_c == S_DMA);
        cnt_cpu  <= bump(cnt_cpu,  nxt_c == S_CPU);
        cnt_idle <= bump(cnt_idle, nxt_c == S_IDLE);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vdram_slot_sched.sv
// Bench for vdram_slot_sched: two instances (TS budget 64 and 3) driven in lockstep
// and checked against a slot-level reference model. Honours VDRAM_SCHED_STATS_EN.
module tb_vdram_slot_sched;

  logic clk;
  logic rst_n;

  vdram_slot_sched_if #(.BUDGET_W(8)) ifa ();
  vdram_slot_sched_if #(.BUDGET_W(8)) ifb ();

  vdram_slot_sched #(.BUDGET_W(8), .TS_BUDGET(8'd64), .CPU_MAXWAIT(4'd6)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  vdram_slot_sched #(.BUDGET_W(8), .TS_BUDGET(8'd3), .CPU_MAXWAIT(4'd6)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int vpn_cnt = 0;

  // Reference model. Owner: 0 idle, 1 vid, 2 ts, 3 dma, 4 cpu.
  int m_param  [2] = '{64, 3};
  int m_owner  [2];
  int m_budget [2];
  int m_wait   [2];
  bit m_rr_cpu [2];
`ifdef VDRAM_SCHED_STATS_EN
  int m_cnt  [2][5];
  int m_stat [2][5];
`endif

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k]  = 0;
      m_budget[k] = m_param[k];
      m_wait[k]   = 0;
      m_rr_cpu[k] = 1'b0;
`ifdef VDRAM_SCHED_STATS_EN
      for (int j = 0; j < 5; j++) begin
        m_cnt[k][j]  = 0;
        m_stat[k][j] = 0;
      end
`endif
    end
  endtask

  task automatic model_step(input int k, input bit vg, input bit ts, input bit dma,
                            input bit cpu, input bit ls, input bit fs);
    int own;
    bit rr;
    bit turn_cpu;
    own = 0;
    rr = 1'b0;
    turn_cpu = fs ? 1'b0 : m_rr_cpu[k];
    if (vg)                       own = 1;
    else if (cpu && m_wait[k] >= 6) own = 4;
    else if (ts && m_budget[k] > 0) own = 2;
    else if (dma && cpu) begin rr = 1'b1; own = turn_cpu ? 4 : 3; end
    else if (dma)        begin rr = 1'b1; own = 3; end
    else if (cpu)        begin rr = 1'b1; own = 4; end
    m_rr_cpu[k] = rr ? (own == 3) : turn_cpu;
    m_wait[k] = (!cpu || own == 4) ? 0 : ((m_wait[k] < 15) ? m_wait[k] + 1 : 15);
    if (ls)            m_budget[k] = m_param[k];
    else if (own == 2) m_budget[k] = m_budget[k] - 1;
`ifdef VDRAM_SCHED_STATS_EN
    if (fs) begin
      for (int j = 0; j < 5; j++) begin
        m_stat[k][j] = m_cnt[k][j];
        m_cnt[k][j]  = 0;
      end
    end
    if (m_cnt[k][own] < 65535) m_cnt[k][own] = m_cnt[k][own] + 1;
`endif
    m_owner[k] = own;
  endtask

  function automatic logic [3:0] gnt_of(input int own);
    logic [3:0] g;
    g = 4'b0000;
    if (own != 0) g[own-1] = 1'b1;
    return g;
  endfunction

  // {gnt, vid_stb, ts_stb, dma_stb, cpu_stb, budget}
  function automatic logic [16:0] exp_vec(input int k, input bit strobes);
    logic [3:0] s;
    s = strobes ? gnt_of(m_owner[k]) : 4'b0000;
    return {gnt_of(m_owner[k]), s[0], s[1], s[2], s[3], 8'(m_budget[k])};
  endfunction

  function automatic logic [16:0] obs_vec(input int k);
    if (k == 0)
      return {ifa.gnt, ifa.video_pre_next, ifa.ts_gnt_stb, ifa.dma_gnt_stb, ifa.cpu_gnt_stb,
              ifa.ts_budget_left};
    return {ifb.gnt, ifb.video_pre_next, ifb.ts_gnt_stb, ifb.dma_gnt_stb, ifb.cpu_gnt_stb,
            ifb.ts_budget_left};
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag, input bit strobes);
    check({tag, "_a"}, 80'(obs_vec(0)), 80'(exp_vec(0, strobes)));
    check({tag, "_b"}, 80'(obs_vec(1)), 80'(exp_vec(1, strobes)));
`ifdef VDRAM_SCHED_STATS_EN
    check({tag, "_stat_a"},
          {ifa.stat_vid, ifa.stat_ts, ifa.stat_dma, ifa.stat_cpu, ifa.stat_idle},
          {16'(m_stat[0][1]), 16'(m_stat[0][2]), 16'(m_stat[0][3]), 16'(m_stat[0][4]),
           16'(m_stat[0][0])});
    check({tag, "_stat_b"},
          {ifb.stat_vid, ifb.stat_ts, ifb.stat_dma, ifb.stat_cpu, ifb.stat_idle},
          {16'(m_stat[1][1]), 16'(m_stat[1][2]), 16'(m_stat[1][3]), 16'(m_stat[1][4]),
           16'(m_stat[1][0])});
`endif
  endtask

  task automatic drive(input bit c3, input bit vg, input bit ts, input bit dma,
                       input bit cpu, input bit ls, input bit fs);
    ifa.c3 = c3; ifa.video_go = vg; ifa.ts_req = ts; ifa.dma_req = dma; ifa.cpu_req = cpu;
    ifa.line_start_s = ls; ifa.frame_start = fs;
    ifb.c3 = c3; ifb.video_go = vg; ifb.ts_req = ts; ifb.dma_req = dma; ifb.cpu_req = cpu;
    ifb.line_start_s = ls; ifb.frame_start = fs;
  endtask

  // One DRAM slot: three hold clocks then the c3 decision clock.
  task automatic run_slot(input bit vg, input bit ts, input bit dma, input bit cpu,
                          input bit ls, input bit fs, input bit jitter);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (jitter)
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
              1'($urandom_range(0, 1)));
      else
        drive(1'b0, vg, ts, dma, cpu, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_model("hold", 1'b0);
    end
    @(negedge clk);
    drive(1'b1, vg, ts, dma, cpu, ls, fs);
    @(posedge clk);
    model_step(0, vg, ts, dma, cpu, ls, fs);
    model_step(1, vg, ts, dma, cpu, ls, fs);
    #1;
    if (ifa.video_pre_next) vpn_cnt++;
    check_model("decide", 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Video window with everything else pending.
    vpn_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      run_slot(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("vid_gnt", 80'(ifa.gnt), 80'(4'b0001));
    end
    check("vid_pulses", 80'(vpn_cnt), 80'(10));

    // Window closes: starved CPU forced first, then TS.
    run_slot(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("cpu_forced", 80'(ifa.gnt), 80'(4'b1000));
    run_slot(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ts_after_cpu", 80'(ifa.gnt), 80'(4'b0010));

    // Line start coinciding with a TS grant reloads to the full budget.
    run_slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("reload_wins_a", 80'(ifa.ts_budget_left), 80'(8'd64));
    check("reload_wins_b", 80'(ifb.ts_budget_left), 80'(8'd3));

    // Small budget exhausts after three grants, then the slot goes idle.
    for (int i = 0; i < 3; i++) begin
      run_slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ts_budget_b", 80'(ifb.ts_budget_left), 80'(2 - i));
    end
    run_slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ts_exhausted_b", 80'(ifb.gnt), 80'(4'b0000));
    run_slot(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ts_line_reload_b", 80'(ifb.ts_budget_left), 80'(8'd3));

    // DMA/CPU round-robin, then frame start restarts at DMA.
    for (int i = 0; i < 5; i++) begin
      run_slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rr_alt", 80'(ifa.gnt), 80'((i % 2 == 0) ? 4'b0100 : 4'b1000));
    end
    run_slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rr_frame_restart", 80'(ifa.gnt), 80'(4'b0100));
    run_slot(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rr_after_frame", 80'(ifa.gnt), 80'(4'b1000));

    // Async reset two clocks into a DMA slot.
    run_slot(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_dma", 80'(ifa.gnt), 80'(4'b0100));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_a", 80'(ifa.gnt), 80'(4'b0000));
    check("async_reset_b", 80'(ifb.gnt), 80'(4'b0000));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_slot(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_dma", 80'(ifa.gnt), 80'(4'b0100));

    // Randomized traffic with requests wiggling between decisions.
    for (int n = 0; n < 400; n++) begin
      run_slot(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vdram_slot_sched.md
Name: vdram_slot_sched

Overview:
- Per-slot DRAM scheduler for the video subsystem.
- Every 4-clock DRAM slot (marked by c3) is granted to exactly one of four requesters: video fetch, TS (tile/sprite) engine, DMA, CPU.
- Video fetch has absolute priority while the raster fetch window is open. TS is limited by a per-line slot budget. DMA and CPU share the remaining slots round-robin, with an anti-starvation override for CPU.
- The block sits between the raster generator (video_go, line/frame strobes) and the DRAM controller, and generates the video_pre_next advance strobe.

Parameters:
- TS_BUDGET, 8'd64, maximum TS slots granted per TV line.
- CPU_MAXWAIT, 4'd6, consecutive denied slots after which a pending CPU request is forced.
- BUDGET_W, 8, width of the TS budget counter.

Ports:
- clk  in  1  system clock (28 MHz domain of the video core)
- rst_n  in  1  asynchronous active-low reset
- c3  in  1  last phase of the 4-clock DRAM cycle; a slot decision is made on clk edges where c3=1
- line_start_s  in  1  TV line start strobe (coincident with c3)
- frame_start  in  1  frame start level from raster generator
- video_go  in  1  raster fetch window active
- ts_req  in  1  TS engine requests a slot (level, held until granted)
- dma_req  in  1  DMA requests a slot (level)
- cpu_req  in  1  CPU requests a slot (level)
- gnt  out  4  one-hot slot owner {cpu,dma,ts,vid}; 4'b0000 = idle slot
- video_pre_next  out  1  one-clock pulse when a video slot is issued
- ts_gnt_stb  out  1  one-clock pulse when a TS slot is issued
- dma_gnt_stb  out  1  one-clock pulse when a DMA slot is issued
- cpu_gnt_stb  out  1  one-clock pulse when a CPU slot is issued
- ts_budget_left  out  BUDGET_W  remaining TS slots on the current line

Behaviour:
- Reset (rst_n=0, async):
  - gnt=0, all strobes=0.
  - ts_budget_left=TS_BUDGET.
  - rr_ptr=DMA, cpu_wait=0.
- Decisions happen only on clk edges with c3=1. gnt is registered and held constant for the following 4 clocks. Strobes are registered and are high for the single clk after the decision edge.
- Slot priority at each decision:
  1. video_go=1 → VID.
  2. cpu_req=1 and cpu_wait>=CPU_MAXWAIT → CPU (forced).
  3. ts_req=1 and ts_budget_left!=0 → TS.
  4. DMA/CPU round-robin among pending requesters; rr_ptr toggles to the other side after each RR grant.
  5. none → idle (gnt=0).
- Arbiter state: IDLE, VID, TS, DMA, CPU. This is the registered owner of the current slot. Every state may transition to any state at the next decision; there is no multi-slot lock.
- TS budget:
  - Decrements by 1 on each TS grant and saturates at 0.
  - Reloads to TS_BUDGET on line_start_s.
  - If line_start_s coincides with a TS grant, reload wins: result is TS_BUDGET, not TS_BUDGET-1.
- cpu_wait:
  - Increments (saturating at 4'hF) on each decision where cpu_req=1 and CPU is not granted.
  - Clears on a CPU grant, or on any decision with cpu_req=0.
  - A VID grant still increments it. The forced CPU grant therefore waits for the video window to close.
- frame_start && c3 also resets rr_ptr to DMA, giving frame-deterministic ordering.
- Requests are sampled only at decision edges. A request that drops between decisions is ignored. Requesters must hold a request until they see their strobe.
- Simultaneous video_go and forced CPU → VID. The CPU override applies on the first non-video slot.
- Reset asserted mid-slot clears gnt immediately (async). The first grant after release occurs at the first c3 edge.

Optional Feature:
- Macro: VDRAM_SCHED_STATS_EN.
- When defined, the following ports are added:
  - stat_vid, stat_ts, stat_dma, stat_cpu: out, 16 bits each. Slots granted to each requester during the previous frame.
  - stat_idle: out, 16 bits. Idle slots during the previous frame.
- Counting:
  - Internal counters increment on each decision and saturate at 16'hFFFF.
  - On frame_start && c3, counter values are copied to the stat_* outputs and the counters restart. The current decision counts toward the new frame.
  - All stat_* outputs reset to 0.
- When undefined, these ports and counters do not exist and scheduling behaviour is identical.

Test Plan:
- video_go=1 and all other requests=1 for 10 decisions → gnt=4'b0001 every slot; video_pre_next pulses 10 times; cpu_wait reaches 10.
- Continue from there: drop video_go with cpu_req=1, ts_req=1 → the first decision grants CPU (forced, cpu_wait≥6) and cpu_wait returns to 0; the next decision grants TS.
- TS_BUDGET=3, ts_req=1 held, no video → 3 TS grants; ts_budget_left goes 2,1,0; following slots go to DMA/CPU or idle. After line_start_s, ts_budget_left=3.
- dma_req=cpu_req=1, ts_req=0, video_go=0 → grants alternate DMA,CPU,DMA,CPU. frame_start restarts the sequence with DMA.
- line_start_s on the same edge as a TS grant with TS_BUDGET=64 → ts_budget_left=64.
- rst_n pulled low two clocks after a DMA grant → gnt=0 asynchronously. After release with dma_req=1, DMA is granted at the first c3 edge.
